pwm_sequencer: RTL and testbench
================================

Name: pwm_sequencer

Overview:
Run/stop controller and configuration manager for the team's counter-based duty-cycle generator. It owns the period counter and produces the duty waveform. It accepts period/high-time configuration over a valid/ready handshake and stages it in shadow registers. Staged configuration is applied only on a period boundary, so a change never produces a runt or stretched pulse. Stop requests are sequenced so the current period always completes.

Parameters:
CNT_W, 8, width of counter and configuration fields
DEF_PERIOD, 10, active period (cycles) after reset
DEF_HIGH, 2, active high time (cycles) after reset (20% duty)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
run  in  1  level; 1 = generate waveform, 0 = stop at end of current period
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted this cycle
cfg_period  in  CNT_W  requested period in cycles
cfg_high  in  CNT_W  requested high time in cycles
cfg_err  out  1  one-cycle pulse: offered config rejected
pwm_out  out  1  duty-cycle waveform
period_tick  out  1  one-cycle pulse in last cycle of each period
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, cnt=0, per_act=DEF_PERIOD, high_act=DEF_HIGH, pending=0, cfg_err=0. Outputs: pwm_out=0, period_tick=0, busy=0, cfg_ready=1. Reset mid-period aborts immediately and discards any pending shadow.
- Handshake: transfer occurs when cfg_valid && cfg_ready at an edge. cfg_valid may be held; the master holds data stable until the transfer.
- Validation: cfg_period < 2 -> transfer is consumed but discarded. cfg_err=1 in the following cycle; no state changes.
- Clamping: cfg_high > cfg_period -> high stored as cfg_period (100%). cfg_high==0 is legal (constant low).
- cfg_ready: 1 in IDLE; in RUN/DRAIN it equals !pending.
- IDLE: an accepted valid config writes per_act/high_act directly at the edge. When run==1, the next state is RUN with cnt=0. If a config is accepted in the same cycle that run rises, the new values take effect for the first period.
- RUN / DRAIN counting: cnt increments each cycle and wraps to 0 when cnt==per_act-1. period_tick=1 exactly when cnt==per_act-1.
- pwm_out = (state is RUN or DRAIN) && (cnt < high_act), decoded from registered state only. Waveform is high for high_act cycles starting at cnt=0, low for per_act-high_act cycles.
- RUN / DRAIN config handling: an accepted valid config goes to shadow and sets pending=1.
- Boundary update: on a period_tick edge with pending=1, per_act/high_act are loaded from shadow and pending is cleared. A config accepted on a period_tick cycle is applied at the following boundary, not the current one.
- RUN: run==0 -> DRAIN (the counter keeps going).
- DRAIN: run==1 -> RUN with no waveform disturbance. Otherwise, on the period_tick edge -> IDLE with cnt=0; any pending shadow is applied on that same edge.
- Width rules: counter and fields are CNT_W unsigned; no overflow is possible since cnt < per_act <= 2^CNT_W-1.
- Latency: run rising in IDLE -> pwm_out high in the next cycle (when high_act>0). busy follows state with no extra delay.

Decomposition:
- Package pwm_seq_pkg: state enum (IDLE, RUN, DRAIN), MIN_PERIOD=2 constant, and a config struct {period, high}.
- One natural sub-module, pwm_period_counter: cnt, wrap, period_tick, and the pwm_out compare against per_act/high_act, enabled by the FSM. The FSM, handshake and shadow logic stay in pwm_sequencer.

Test Plan:
- Reset defaults: release rst, assert run -> pwm_out high 2 cycles, low 8, repeating; period_tick every 10th cycle; busy=1.
- Live reconfig: while running, offer period=8/high=4 mid-period. Expect: accepted, then cfg_ready=0 until the boundary; the current 10-cycle period completes unchanged; the next period is 4 high / 4 low; cfg_ready returns to 1.
- Rejection and clamp: offer period=1 -> cfg_err pulse, waveform unchanged. Offer period=5/high=9 -> after the boundary pwm_out is constant high, period_tick every 5 cycles.
- Graceful stop: drop run at cnt=3 of a 10-cycle period -> DRAIN; the period finishes, period_tick fires, IDLE with pwm_out=0, busy=0 next cycle. In a second run, re-raise run during DRAIN -> no gap in the waveform.
- Reset mid-operation: pending config staged, assert rst at cnt=6 -> next cycle all outputs are at reset values. After release plus run, the default 10/2 waveform appears (the pending config is discarded).
- Edge coincidences: a config accepted on the period_tick cycle is applied one period later. high=0 gives a constant-low output while period_tick continues.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM sequencer: FSM states, the
// minimum legal period and the staged-configuration record.
package pwm_seq_pkg;

    localparam int CFG_W      = 8;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } cfg_t;

    // High time beyond the period saturates to 100% duty.
    function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] period,
                                       input logic [CFG_W-1:0] high);
        cfg_t c;
        c.period = period;
        c.high   = (high > period) ? period : high;
        return c;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter and duty compare. Holds at zero while disabled, wraps at
// per_act-1 and flags that last cycle with period_tick.
module pwm_period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] per_act,
    input  logic [CNT_W-1:0] high_act,
    output logic             period_tick,
    output logic             pwm_out
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == per_act - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign period_tick = en && wrap;
    assign pwm_out     = en && (cnt < high_act);

endmodule

// File: rtl/pwm_sequencer.sv
// Run/stop FSM, configuration handshake and shadow staging around the
// period counter. New settings only take effect on a period boundary.
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int CNT_W      = CFG_W,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             pwm_out,
    output logic             period_tick,
    output logic             busy
);

    // Handshake: a config transfers on any rising edge where cfg_valid and
    // cfg_ready are both high; the master keeps data stable until then.

    state_t           state;
    logic [CNT_W-1:0] per_act;
    logic [CNT_W-1:0] high_act;
    cfg_t             shadow;
    logic             pending;
    cfg_t             cfg_in;
    logic             xfer;
    logic             cfg_ok;

    assign cfg_in    = clamp_cfg(CFG_W'(cfg_period), CFG_W'(cfg_high));
    assign cfg_ready = (state == IDLE) || !pending;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = (cfg_period >= CNT_W'(MIN_PERIOD));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            per_act  <= CNT_W'(DEF_PERIOD);
            high_act <= CNT_W'(DEF_HIGH);
            shadow   <= '0;
            pending  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= xfer && !cfg_ok;

            case (state)
                IDLE: begin
                    if (xfer && cfg_ok) begin
                        per_act  <= CNT_W'(cfg_in.period);
                        high_act <= CNT_W'(cfg_in.high);
                    end
                    if (run) state <= RUN;
                end
                RUN: begin
                    if (!run) state <= DRAIN;
                end
                DRAIN: begin
                    if (run) state <= RUN;
                    else if (period_tick) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // cfg_ready is low while pending, so a load and a new stage never collide.
            if (state != IDLE) begin
                if (period_tick && pending) begin
                    per_act  <= CNT_W'(shadow.period);
                    high_act <= CNT_W'(shadow.high);
                    pending  <= 1'b0;
                end
                if (xfer && cfg_ok) begin
                    shadow  <= cfg_in;
                    pending <= 1'b1;
                end
            end
        end
    end

    pwm_period_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (state != IDLE),
        .per_act    (per_act),
        .high_act   (high_act),
        .period_tick(period_tick),
        .pwm_out    (pwm_out)
    );

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: directed stimulus pushes expected per-period
// {length, high cycles} records; a negedge monitor measures and compares.
module tb_pwm_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_err;
    logic       pwm_out;
    logic       period_tick;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int len    = 0;
    int hi     = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  err_q[$];

    pwm_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_period(input int l, input int h);
        exp_q.push_back({8'(l), 8'(h)});
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!period_tick && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (!period_tick) begin
            errors++;
            $display("FAIL tick_timeout actual=no_tick required=tick");
        end
    endtask

    task automatic send_cfg(input logic [7:0] p, input logic [7:0] h);
        int n = 0;
        cfg_period = p;
        cfg_high   = h;
        cfg_valid  = 1'b1;
        while (!cfg_ready && n < 300) begin
            step(1);
            n++;
        end
        check1("cfg_accept", cfg_ready, 1'b1);
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Monitor: measures each period between ticks and pops its expectation.
    always @(negedge clk) begin
        if (!rst) begin
            len = 0;
            hi  = 0;
        end else begin
            if (busy) begin
                len++;
                if (pwm_out) hi++;
            end else begin
                checks++;
                if (pwm_out || period_tick) begin
                    errors++;
                    $display("FAIL idle_quiet actual=pwm%0b_tick%0b required=pwm0_tick0",
                             pwm_out, period_tick);
                end
            end
            if (period_tick) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL period_unexpected actual=len%0d_hi%0d required=none", len, hi);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({8'(len), 8'(hi)} !== e) begin
                        errors++;
                        $display("FAIL period actual=len%0d_hi%0d required=len%0d_hi%0d",
                                 len, hi, e[15:8], e[7:0]);
                    end
                end
                len = 0;
                hi  = 0;
            end
            if (cfg_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg_err_unexpected actual=1 required=0");
                end else begin
                    void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0;
        step(3);
        check1("rst_pwm", pwm_out, 1'b0);
        check1("rst_tick", period_tick, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready", cfg_ready, 1'b1);
        check1("rst_err", cfg_err, 1'b0);

        // Defaults 10/2 after reset
        rst = 1'b1;
        step(1);
        push_period(10, 2);
        push_period(10, 2);
        run = 1'b1;
        step(1);
        check1("start_pwm", pwm_out, 1'b1);
        check1("start_busy", busy, 1'b1);
        wait_tick();
        step(1);
        wait_tick();

        // Live reconfig mid-period
        push_period(10, 2);
        push_period(8, 4);
        step(4);
        send_cfg(8'd8, 8'd4);
        check1("pending_ready", cfg_ready, 1'b0);
        wait_tick();
        check1("pending_ready_tick", cfg_ready, 1'b0);
        step(1);
        check1("applied_ready", cfg_ready, 1'b1);
        wait_tick();

        // Rejection then clamp
        push_period(8, 4);
        step(1);
        err_q.push_back(8'd1);
        send_cfg(8'd1, 8'd0);
        check1("reject_err", cfg_err, 1'b1);
        check1("reject_ready", cfg_ready, 1'b1);
        send_cfg(8'd5, 8'd9);
        push_period(5, 5);
        push_period(5, 5);
        wait_tick();
        step(1);
        wait_tick();
        step(1);
        wait_tick();

        // Graceful stop
        push_period(5, 5);
        push_period(10, 2);
        step(1);
        send_cfg(8'd10, 8'd2);
        wait_tick();
        step(4);
        run = 1'b0;
        wait_tick();
        check1("drain_busy", busy, 1'b1);
        step(1);
        check1("stopped_busy", busy, 1'b0);
        check1("stopped_pwm", pwm_out, 1'b0);
        step(3);

        // Re-raise run during drain
        push_period(10, 2);
        push_period(10, 2);
        push_period(10, 2);
        run = 1'b1;
        step(1);
        wait_tick();
        step(3);
        run = 1'b0;
        step(3);
        run = 1'b1;
        wait_tick();
        step(1);
        check1("rerun_busy", busy, 1'b1);
        wait_tick();

        // Reset mid-period discards the staged config
        step(1);
        send_cfg(8'd6, 8'd3);
        step(5);
        rst = 1'b0;
        step(1);
        check1("mid_rst_pwm", pwm_out, 1'b0);
        check1("mid_rst_tick", period_tick, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_ready", cfg_ready, 1'b1);
        push_period(10, 2);
        push_period(10, 2);
        rst = 1'b1;
        wait_tick();
        step(1);
        wait_tick();

        // Config accepted on the tick cycle lands one period later; high=0
        push_period(10, 2);
        push_period(4, 0);
        push_period(4, 0);
        send_cfg(8'd4, 8'd0);
        check1("tick_cfg_pending", cfg_ready, 1'b0);
        wait_tick();
        step(1);
        wait_tick();
        step(1);
        wait_tick();
        push_period(4, 0);
        run = 1'b0;
        step(1);
        wait_tick();
        step(1);
        check1("idle2_busy", busy, 1'b0);

        // Config in IDLE together with run rising applies to first period
        push_period(3, 1);
        push_period(3, 1);
        push_period(3, 1);
        run = 1'b1;
        send_cfg(8'd3, 8'd1);
        check1("idle_cfg_pwm", pwm_out, 1'b1);
        wait_tick();
        step(1);
        wait_tick();
        run = 1'b0;
        step(1);
        wait_tick();
        step(1);
        check1("final_busy", busy, 1'b0);
        step(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL periods_left actual=%0d required=0", exp_q.size());
        end
        checks++;
        if (err_q.size() != 0) begin
            errors++;
            $display("FAIL cfg_err_missing actual=%0d required=0", err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
